halt_reporter: RTL and testbench
================================

HALT_REPORTER -- requirements
Module: halt_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: UART bit period in clk cycles (50 MHz / 115200); legal range >= 2.
REQ-002 SHALL have parameter CYCLE_LIMIT, default 500000: cycle count at which the run is declared timed out.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port isHalt  input  1  CPU halt indication, sampled each clk edge.
REQ-006 SHALL have port ret_val  input  16  CPU return value, sampled with isHalt.
REQ-007 SHALL have port uart_tx  output  1  serial result line, 8N1, idle high.
REQ-008 SHALL have port cpu_stop  output  1  high from capture onward; freezes the CPU.
REQ-009 SHALL have port busy  output  1  high while a frame is being transmitted.
REQ-010 SHALL have port done  output  1  high after the final stop bit; sticky until reset.

Function
REQ-011 SHALL implement states COUNT, SEND and DONE.
REQ-012 SHALL hold a 32-bit cycle counter that increments by 1 on every clk edge while in COUNT.
REQ-013 SHALL, in COUNT with isHalt=1, capture count (pre-increment value), ret_val and status 0x01, then enter SEND on the next cycle.
REQ-014 SHALL, in COUNT with isHalt=0 and count==CYCLE_LIMIT, capture count, ret_val and status 0x02, then enter SEND.
REQ-015 SHALL give halt priority when isHalt=1 and count==CYCLE_LIMIT occur together: status 0x01.
REQ-016 SHALL freeze the counter in SEND and DONE; it SHALL never wrap.
REQ-017 SHALL transmit a 9-byte frame in this order: 0xA5, status, count[7:0], count[15:8], count[23:16], count[31:24], ret_val[7:0], ret_val[15:8], checksum.
REQ-018 SHALL compute checksum as the XOR of frame bytes 1..7 (status through ret_val[15:8]).
REQ-019 SHALL send each byte as: start bit 0, 8 data bits LSB first, stop bit 1; each bit CLKS_PER_BIT cycles.
REQ-020 SHALL send bytes back-to-back, the next start bit immediately following the previous stop bit.
REQ-021 SHALL drive uart_tx low (first start bit) on the first cycle in SEND.
REQ-022 SHALL make the frame occupy exactly 90*CLKS_PER_BIT cycles in SEND, then enter DONE.
REQ-023 SHALL, in DONE, hold uart_tx=1, busy=0, done=1, cpu_stop=1, and ignore isHalt.
REQ-024 SHALL assert busy exactly while in SEND.
REQ-025 SHALL assert cpu_stop from the cycle after capture and keep it high through SEND and DONE.
REQ-026 SHALL sample ret_val only at capture; later changes SHALL NOT affect the frame.

Reset
REQ-027 SHALL, on rst=1 (asynchronous), immediately force state COUNT, count=0, uart_tx=1, busy=0, done=0, cpu_stop=0, and clear captured registers.
REQ-028 SHALL abort any frame in progress on reset mid-SEND, with uart_tx high the same instant; no partial-frame resume.
REQ-029 SHALL make the first counted cycle after rst deassertion count=0.

Verification (CLKS_PER_BIT=4, CYCLE_LIMIT=100)
REQ-030 SHALL check: release rst, assert isHalt when count==37 with ret_val=0x1234 -> frame A5 01 25 00 00 00 34 12 02; busy high for 360 cycles; then done=1.
REQ-031 SHALL check: isHalt never asserted -> at count==100, frame A5 02 64 00 00 00 xx xx with correct XOR; cpu_stop=1.
REQ-032 SHALL check: isHalt=1 on the cycle count==100 -> status 0x01, count bytes 64 00 00 00.
REQ-033 SHALL check: assert rst at byte 4 of a frame -> uart_tx=1 immediately, busy=0; a new halt at count==5 yields a complete correct frame.
REQ-034 SHALL check: isHalt pulses and ret_val changes during SEND and DONE -> frame unchanged, exactly one frame sent, done stays 1.
REQ-035 SHALL check: bit timing -> every uart_tx level held exactly 4 cycles; line idle high before SEND and after DONE.

Source files
------------

// File: rtl/halt_reporter.sv
// Counts CPU cycles until halt or timeout, then reports status, cycle count,
// return value and an XOR checksum as a single 9-byte 8N1 UART frame.
module halt_reporter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CYCLE_LIMIT  = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isHalt,
  input  logic [15:0] ret_val,
  output logic        uart_tx,
  output logic        cpu_stop,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [3:0]  LAST_BYTE = 4'd8;
  localparam logic [3:0]  STOP_POS  = 4'd9;

  typedef enum logic [1:0] {S_COUNT, S_SEND, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cap_cnt_q, cap_cnt_d;
  logic [15:0]        cap_ret_q, cap_ret_d;
  logic [7:0]         cap_sts_q, cap_sts_d;
  logic [7:0]         cap_chk_q, cap_chk_d;
  logic [3:0]         byte_q, byte_d;
  logic [3:0]         bit_q, bit_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               tx_q, tx_d;
  logic               stop_q, stop_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         cur_byte_c;

  // State register; reset also drives the line idle and drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_COUNT;
      count_q   <= '0;
      cap_cnt_q <= '0;
      cap_ret_q <= '0;
      cap_sts_q <= '0;
      cap_chk_q <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      tick_q    <= '0;
      tx_q      <= 1'b1;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cap_cnt_q <= cap_cnt_d;
      cap_ret_q <= cap_ret_d;
      cap_sts_q <= cap_sts_d;
      cap_chk_q <= cap_chk_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      tick_q    <= tick_d;
      tx_q      <= tx_d;
      stop_q    <= stop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state: capture on halt (priority) or limit, then walk bytes/bits/ticks.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cap_cnt_d = cap_cnt_q;
    cap_ret_d = cap_ret_q;
    cap_sts_d = cap_sts_q;
    cap_chk_d = cap_chk_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    tick_d    = tick_q;
    unique case (state_q)
      S_COUNT: begin
        count_d = count_q + 32'd1;
        if (isHalt || (count_q == 32'(CYCLE_LIMIT))) begin
          cap_cnt_d = count_q;
          cap_ret_d = ret_val;
          cap_sts_d = isHalt ? 8'h01 : 8'h02;
          cap_chk_d = cap_sts_d ^ count_q[7:0] ^ count_q[15:8] ^ count_q[23:16]
                    ^ count_q[31:24] ^ ret_val[7:0] ^ ret_val[15:8];
          state_d   = S_SEND;
          byte_d    = '0;
          bit_d     = '0;
          tick_d    = '0;
        end
      end
      S_SEND: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == STOP_POS) begin
            bit_d = '0;
            if (byte_q == LAST_BYTE) state_d = S_DONE;
            else                     byte_d  = byte_q + 4'd1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_DONE: ;
      default: state_d = S_COUNT;
    endcase
  end

  // Outputs are registered from the next-state values so the start bit lands on SEND's first cycle.
  always_comb begin
    case (byte_d)
      4'd0:    cur_byte_c = SYNC_BYTE;
      4'd1:    cur_byte_c = cap_sts_q;
      4'd2:    cur_byte_c = cap_cnt_q[7:0];
      4'd3:    cur_byte_c = cap_cnt_q[15:8];
      4'd4:    cur_byte_c = cap_cnt_q[23:16];
      4'd5:    cur_byte_c = cap_cnt_q[31:24];
      4'd6:    cur_byte_c = cap_ret_q[7:0];
      4'd7:    cur_byte_c = cap_ret_q[15:8];
      default: cur_byte_c = cap_chk_q;
    endcase
    tx_d = 1'b1;
    if (state_d == S_SEND) begin
      if (bit_d == 4'd0)          tx_d = 1'b0;
      else if (bit_d == STOP_POS) tx_d = 1'b1;
      else                        tx_d = cur_byte_c[3'(bit_d - 4'd1)];
    end
    busy_d = (state_d == S_SEND);
    stop_d = (state_d != S_COUNT);
    done_d = (state_d == S_DONE);
  end

  assign uart_tx  = tx_q;
  assign cpu_stop = stop_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_halt_reporter.sv
// Randomized bench for halt_reporter: a frame-level reference model predicts
// capture cycle, frame bytes and per-cycle line level.
module tb_halt_reporter;

  localparam int CPB       = 4;
  localparam int LIM       = 100;
  localparam int FRAME_CYC = 90 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        isHalt = 1'b0;
  logic [15:0] ret_val = 16'h0000;
  logic        uart_tx, cpu_stop, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_frame [9];
  int         exp_cap;

  halt_reporter #(.CLKS_PER_BIT(CPB), .CYCLE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .isHalt(isHalt), .ret_val(ret_val),
    .uart_tx(uart_tx), .cpu_stop(cpu_stop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Frame predicted from the capture rules: halt wins, otherwise the limit fires.
  task automatic model(input int halt_at, input logic [15:0] rv);
    bit          halted;
    logic [31:0] c32;
    logic [7:0]  x;
    halted  = (halt_at >= 0) && (halt_at <= LIM);
    exp_cap = halted ? halt_at : LIM;
    c32     = 32'(exp_cap);
    exp_frame[0] = 8'hA5;
    exp_frame[1] = halted ? 8'h01 : 8'h02;
    exp_frame[2] = c32[7:0];
    exp_frame[3] = c32[15:8];
    exp_frame[4] = c32[23:16];
    exp_frame[5] = c32[31:24];
    exp_frame[6] = rv[7:0];
    exp_frame[7] = rv[15:8];
    x = 8'h00;
    for (int b = 1; b <= 7; b++) x = x ^ exp_frame[b];
    exp_frame[8] = x;
  endtask

  function automatic logic exp_bit(input int i);
    int p, b, k;
    p = i / CPB;
    b = p / 10;
    k = p % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return exp_frame[b][k-1];
  endfunction

  task automatic run_frame(input int halt_at, input logic [15:0] rv, input int abort_at);
    logic       tx_s [FRAME_CYC];
    logic [7:0] got;
    model(halt_at, rv);
    rst = 1'b1;
    isHalt = 1'b0;
    ret_val = 16'($urandom);
    @(posedge clk); #1;
    chk("reset_tx", 32'(uart_tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_cpu_stop", 32'(cpu_stop), 32'd0);
    rst = 1'b0;
    for (int c = 0; c <= exp_cap; c++) begin
      isHalt  = (c == halt_at);
      ret_val = (c == exp_cap) ? rv : 16'($urandom);
      @(posedge clk); #1;
      chk("count_cpu_stop", 32'(cpu_stop), 32'(c == exp_cap));
      chk("count_tx", 32'(uart_tx), 32'(c != exp_cap));
      chk("count_busy", 32'(busy), 32'(c == exp_cap));
    end
    for (int i = 0; i < FRAME_CYC; i++) begin
      tx_s[i] = uart_tx;
      chk("send_tx_level", 32'(uart_tx), 32'(exp_bit(i)));
      chk("send_busy", 32'(busy), 32'd1);
      chk("send_cpu_stop", 32'(cpu_stop), 32'd1);
      chk("send_done", 32'(done), 32'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(uart_tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_stop", 32'(cpu_stop), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        return;
      end
      isHalt  = 1'($urandom);
      ret_val = 16'($urandom);
      @(posedge clk); #1;
    end
    for (int j = 0; j < 16; j++) begin
      chk("done_flag", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_tx", 32'(uart_tx), 32'd1);
      chk("done_cpu_stop", 32'(cpu_stop), 32'd1);
      isHalt  = 1'($urandom);
      ret_val = 16'($urandom);
      @(posedge clk); #1;
    end
    for (int b = 0; b < 9; b++) begin
      for (int k = 0; k < 8; k++) got[k] = tx_s[(b * 10 + 1 + k) * CPB + CPB / 2];
      chk($sformatf("frame_byte%0d", b), 32'(got), 32'(exp_frame[b]));
    end
  endtask

  initial begin
    int h;
    run_frame(37, 16'h1234, -1);
    run_frame(-1, 16'($urandom), -1);
    run_frame(LIM, 16'($urandom), -1);
    run_frame(20, 16'($urandom), 4 * 10 * CPB + 6);
    run_frame(5, 16'($urandom), -1);
    run_frame(0, 16'($urandom), -1);
    for (int r = 0; r < 4; r++) begin
      h = int'($urandom_range(0, 120));
      run_frame(h, 16'($urandom), -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
